// File: rtl/vm2002_coin_credit.sv
// vm2002 coin credit stage: coin intake, debit answers and greedy change return.
// Optional macro VM2002_AUTO_CHANGE_EN: a successful debit with leftover credit starts change on its own.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | accepting coins, debits and refund requests
// ST_CHANGE | paying out credit one coin at a time over change_valid/ready
// ST_DONE   | one-cycle change_done pulse, then back to ST_IDLE
module vm2002_coin_credit #(
  parameter int unsigned          CREDIT_W   = 16,
  parameter logic [CREDIT_W-1:0]  MAX_CREDIT = 16'd995
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid_i,
  input  logic [1:0]          coin_code_i,
  output logic                coin_reject_o,
  input  logic                debit_req_i,
  input  logic [CREDIT_W-1:0] debit_amt_i,
  output logic                debit_ack_o,
  output logic                debit_ok_o,
  input  logic                refund_req_i,
  output logic                change_valid_o,
  output logic [1:0]          change_coin_o,
  input  logic                change_ready_i,
  output logic                change_done_o,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHANGE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                coin_reject_q, coin_reject_d;
  logic                debit_ack_q, debit_ack_d;
  logic                debit_ok_q, debit_ok_d;

  logic [CREDIT_W-1:0] coin_val;
  logic                credit_enough;
  logic [CREDIT_W-1:0] post_debit;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_fits;
  logic [1:0]          greedy_code;
  logic [CREDIT_W-1:0] greedy_val;

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
    case (code)
      2'd0:    coin_value = CREDIT_W'(5);
      2'd1:    coin_value = CREDIT_W'(10);
      2'd2:    coin_value = CREDIT_W'(25);
      default: coin_value = CREDIT_W'(100);
    endcase
  endfunction

  // Debit is judged on pre-coin credit; the coin overflow check then sees the post-debit value.
  always_comb begin
    coin_val      = coin_value(coin_code_i);
    credit_enough = (credit_q >= debit_amt_i);
    post_debit    = (debit_req_i && credit_enough) ? (credit_q - debit_amt_i) : credit_q;
    coin_sum      = {1'b0, post_debit} + {1'b0, coin_val};
    coin_fits     = (coin_sum <= {1'b0, MAX_CREDIT});
  end

  always_comb begin
    if (credit_q >= CREDIT_W'(25)) begin
      greedy_code = 2'd2;
      greedy_val  = CREDIT_W'(25);
    end else if (credit_q >= CREDIT_W'(10)) begin
      greedy_code = 2'd1;
      greedy_val  = CREDIT_W'(10);
    end else begin
      greedy_code = 2'd0;
      greedy_val  = CREDIT_W'(5);
    end
  end

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    coin_reject_d = 1'b0;
    debit_ack_d   = debit_req_i;
    debit_ok_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        debit_ok_d    = debit_req_i && credit_enough;
        coin_reject_d = coin_valid_i && !coin_fits;
        credit_d      = (coin_valid_i && coin_fits) ? coin_sum[CREDIT_W-1:0] : post_debit;
        if (refund_req_i) begin
          state_d = (credit_d != '0) ? ST_CHANGE : ST_DONE;
        end
`ifdef VM2002_AUTO_CHANGE_EN
        else if (debit_ok_d && (credit_d != '0)) begin
          state_d = ST_CHANGE;
        end
`endif
      end

      ST_CHANGE: begin
        coin_reject_d = coin_valid_i;
        if (change_ready_i) begin
          // Saturate so a stray sub-nickel residue can never wrap.
          credit_d = (credit_q > greedy_val) ? (credit_q - greedy_val) : '0;
          if (credit_d == '0) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        coin_reject_d = coin_valid_i;
        state_d       = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      credit_q      <= '0;
      coin_reject_q <= 1'b0;
      debit_ack_q   <= 1'b0;
      debit_ok_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      coin_reject_q <= coin_reject_d;
      debit_ack_q   <= debit_ack_d;
      debit_ok_q    <= debit_ok_d;
    end
  end

  assign coin_reject_o  = coin_reject_q;
  assign debit_ack_o    = debit_ack_q;
  assign debit_ok_o     = debit_ok_q;
  assign credit_o       = credit_q;
  assign change_valid_o = (state_q == ST_CHANGE);
  assign change_coin_o  = (state_q == ST_CHANGE) ? greedy_code : 2'd0;
  assign change_done_o  = (state_q == ST_DONE);
  assign busy_o         = (state_q == ST_CHANGE) || (state_q == ST_DONE);

endmodule

// File: tb/tb_vm2002_coin_credit.sv
// Scoreboard bench for vm2002_coin_credit: a coin-level reference model predicts every
// post-edge output snapshot; a monitor pops and compares one snapshot per clock.
module tb_vm2002_coin_credit;

  logic        clk;
  logic        rst;
  logic        coin_valid;
  logic [1:0]  coin_code;
  logic        coin_reject;
  logic        debit_req;
  logic [15:0] debit_amt;
  logic        debit_ack;
  logic        debit_ok;
  logic        refund_req;
  logic        change_valid;
  logic [1:0]  change_coin;
  logic        change_ready;
  logic        change_done;
  logic [15:0] credit;
  logic        busy;

  vm2002_coin_credit dut (
    .clk            (clk),
    .rst            (rst),
    .coin_valid_i   (coin_valid),
    .coin_code_i    (coin_code),
    .coin_reject_o  (coin_reject),
    .debit_req_i    (debit_req),
    .debit_amt_i    (debit_amt),
    .debit_ack_o    (debit_ack),
    .debit_ok_o     (debit_ok),
    .refund_req_i   (refund_req),
    .change_valid_o (change_valid),
    .change_coin_o  (change_coin),
    .change_ready_i (change_ready),
    .change_done_o  (change_done),
    .credit_o       (credit),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int rej;
    int ack;
    int ok;
    int cred;
    int cv;
    int cc;
    int done;
    int bsy;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Reference model: credit in cents, a mode (0 idle, 1 paying out, 2 done) and the
  // list of change coins still owed, worked out greedily when payout starts.
  int m_credit = 0;
  int m_mode   = 0;
  int m_pend[$];

  function automatic int cents(input int code);
    case (code)
      0:       return 5;
      1:       return 10;
      2:       return 25;
      default: return 100;
    endcase
  endfunction

  task automatic plan_change(input int amount);
    int rest;
    rest = amount;
    m_pend.delete();
    while (rest >= 25) begin m_pend.push_back(2); rest -= 25; end
    while (rest >= 10) begin m_pend.push_back(1); rest -= 10; end
    while (rest >= 5)  begin m_pend.push_back(0); rest -= 5;  end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: one snapshot per clock, sampled 1ns after the active edge.
  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("credit",       int'(credit),       e.cred);
        chk("coin_reject",  int'(coin_reject),  e.rej);
        chk("debit_ack",    int'(debit_ack),    e.ack);
        chk("debit_ok",     int'(debit_ok),     e.ok);
        chk("change_valid", int'(change_valid), e.cv);
        chk("change_coin",  int'(change_coin),  e.cc);
        chk("change_done",  int'(change_done),  e.done);
        chk("busy",         int'(busy),         e.bsy);
      end
    end
  end

  task automatic step(input logic cv, input logic [1:0] cc, input logic dr,
                      input logic [15:0] amt, input logic rf, input logic rdy,
                      input logic r);
    exp_t e;
    int   c;
    bit   ok;
    rst          = r;
    coin_valid   = cv;
    coin_code    = cc;
    debit_req    = dr;
    debit_amt    = amt;
    refund_req   = rf;
    change_ready = rdy;

    e.rej = 0; e.ack = 0; e.ok = 0;
    if (r) begin
      m_credit = 0;
      m_mode   = 0;
      m_pend.delete();
    end else if (m_mode == 0) begin
      ok = dr && (m_credit >= int'(amt));
      c  = ok ? m_credit - int'(amt) : m_credit;
      if (cv) begin
        if (c + cents(int'(cc)) <= 995) c = c + cents(int'(cc));
        else e.rej = 1;
      end
      e.ack    = int'(dr);
      e.ok     = int'(ok);
      m_credit = c;
      if (rf) begin
        if (c > 0) begin m_mode = 1; plan_change(c); end
        else m_mode = 2;
      end
`ifdef VM2002_AUTO_CHANGE_EN
      else if (ok && c > 0) begin
        m_mode = 1;
        plan_change(c);
      end
`endif
    end else if (m_mode == 1) begin
      e.rej = int'(cv);
      e.ack = int'(dr);
      if (rdy) begin
        m_credit -= cents(m_pend[0]);
        void'(m_pend.pop_front());
        if (m_pend.size() == 0) m_mode = 2;
      end
    end else begin
      e.rej  = int'(cv);
      e.ack  = int'(dr);
      m_mode = 0;
    end

    e.cred = m_credit;
    e.cv   = (m_mode == 1) ? 1 : 0;
    e.cc   = (m_mode == 1) ? m_pend[0] : 0;
    e.done = (m_mode == 2) ? 1 : 0;
    e.bsy  = (m_mode != 0) ? 1 : 0;
    sb.push_back(e);

    @(posedge clk);
    #2;
  endtask

  task automatic nop();
    step(1'b0, 2'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic coin(input logic [1:0] c);
    step(1'b1, c, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic debit(input logic [15:0] a);
    step(1'b0, 2'd0, 1'b1, a, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic reset_cycle();
    step(1'b0, 2'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
  endtask

  // Pays out whatever is left with the dispenser always ready; bounded by a cycle budget.
  task automatic drain();
    int guard;
    if (m_mode == 0) step(1'b0, 2'd0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    guard = 0;
    while (m_mode != 0 && guard < 300) begin
      step(1'b0, 2'd0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
      guard++;
    end
  endtask

  task automatic random_phase(input int n, input int p_coin, input int p_refund);
    for (int i = 0; i < n; i++) begin
      logic        cv, dr, rf, rdy, r;
      logic [1:0]  cc;
      logic [15:0] amt;
      cv  = ($urandom_range(99) < p_coin);
      cc  = 2'($urandom_range(3));
      dr  = ($urandom_range(99) < 20);
      amt = 16'(5 * $urandom_range(60));
      rf  = ($urandom_range(99) < p_refund);
      rdy = ($urandom_range(99) < 60);
      r   = ($urandom_range(199) == 0);
      step(cv, cc, dr, amt, rf, rdy, r);
    end
  endtask

  initial begin
    rst = 1'b1; coin_valid = 1'b0; coin_code = 2'd0; debit_req = 1'b0;
    debit_amt = 16'd0; refund_req = 1'b0; change_ready = 1'b0;

    reset_cycle();
    reset_cycle();
    nop();

    coin(2'd2); coin(2'd2); coin(2'd1);           // 60
    debit(16'd75);                                // refused
    debit(16'd45);                                // 15 left
    step(1'b0, 2'd0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    drain();
    nop();

    for (int i = 0; i < 9; i++) coin(2'd3);
    coin(2'd2); coin(2'd2); coin(2'd2); coin(2'd1); coin(2'd0);  // 990
    coin(2'd0);                                   // 995
    coin(2'd1);                                   // rejected at cap
    coin(2'd3);
    drain();
    nop();

    coin(2'd2); coin(2'd1); coin(2'd0);           // 40
    step(1'b0, 2'd0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 2'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd1, 1'b1, 16'd5, 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'd0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    reset_cycle();
    nop();

    coin(2'd3);                                   // 100
    debit(16'd65);
    drain();
    nop();

    step(1'b0, 2'd0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0);  // refund on zero credit
    nop();
    coin(2'd1);
    step(1'b1, 2'd2, 1'b1, 16'd10, 1'b0, 1'b0, 1'b0); // debit and coin together
    step(1'b1, 2'd0, 1'b1, 16'd25, 1'b1, 1'b1, 1'b0);
    drain();

    random_phase(1500, 30, 8);
    drain();
    random_phase(1500, 70, 1);
    drain();
    nop();
    nop();

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vm2002_coin_credit.md
Name: vm2002_coin_credit

Overview:
- Upstream credit stage of the vm2002 vending machine.
- Accepts coin insertions, keeps the customer credit in cents, and answers debit (purchase) requests from the vend controller.
- Returns change one coin at a time through a ready/valid change-dispense handshake.
- The vend controller uses credit as its balance source and debit_ok to decide whether to release a product.

Parameters:
- MAX_CREDIT, 16'd995: highest credit in cents. A coin that would push credit above this value is rejected.
- CREDIT_W, 16: width of the credit and amount datapaths in bits.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- coin_valid  input  1  one-cycle pulse: a coin is present on coin_code
- coin_code  input  2  0 = nickel (5), 1 = dime (10), 2 = quarter (25), 3 = dollar (100)
- coin_reject  output  1  one-cycle pulse: the coin was not accepted and must be physically returned
- debit_req  input  1  one-cycle pulse: purchase request
- debit_amt  input  CREDIT_W  price in cents; always a multiple of 5
- debit_ack  output  1  one-cycle pulse answering debit_req
- debit_ok  output  1  qualifies debit_ack: 1 = credit was sufficient and has been deducted
- refund_req  input  1  one-cycle pulse: return all credit as change
- change_valid  output  1  a change coin is presented on change_coin
- change_coin  output  2  same encoding as coin_code; only 0, 1 or 2 are ever produced
- change_ready  input  1  the dispenser has taken the presented coin
- change_done  output  1  one-cycle pulse: the change sequence is complete
- credit  output  CREDIT_W  current credit in cents (registered)
- busy  output  1  high while in the CHANGE or DONE state

Behaviour:
- Reset values: credit = 0, state = IDLE, and coin_reject, debit_ack, debit_ok, change_valid, change_done and busy all = 0. change_coin = 0.
- Reset is synchronous. If it is asserted mid-change, the FSM returns to IDLE and credit clears at the next edge; any pending change is discarded.
- Coin values are 5, 10, 25 and 100. All credit arithmetic is unsigned CREDIT_W bits.
- The credit comparison uses a CREDIT_W+1 bit sum so a coin cannot cause wrap-around.
- Latency: every input event is sampled at edge N. credit and the response pulses are valid after edge N (one-cycle registered latency).
- IDLE, coin: if credit + value <= MAX_CREDIT, credit increases by value. Otherwise credit is unchanged and coin_reject pulses.
- IDLE, debit: debit_ack pulses.
  - If credit >= debit_amt: debit_ok = 1 and credit decreases by debit_amt.
  - Otherwise debit_ok = 0 and credit is unchanged.
- Same-cycle priority in IDLE:
  - The debit is evaluated against the pre-coin credit.
  - The accepted coin is then added: credit_next = credit - (ok ? debit_amt : 0) + coin.
  - The overflow check uses the post-debit value.
- IDLE, refund_req:
  - If the post-debit/post-coin credit is nonzero, go to CHANGE.
  - If it is zero, go directly to DONE.
- CHANGE state:
  - change_valid = 1.
  - change_coin is the largest of quarter, dime or nickel whose value <= credit (greedy).
  - On a cycle with change_ready = 1, credit decreases by that coin's value.
  - When the new credit = 0, go to DONE; otherwise stay in CHANGE.
  - change_coin is recomputed from the registered credit every cycle and is held stable while change_ready = 0.
- DONE state: change_done = 1 for one cycle, then return to IDLE.
- While busy:
  - coin_valid causes a coin_reject pulse and credit is unchanged.
  - debit_req causes debit_ack = 1 with debit_ok = 0.
  - refund_req is ignored.
- debit_ack and coin_reject can pulse in the same cycle.

Optional Feature:
- Macro VM2002_AUTO_CHANGE_EN.
- When defined:
  - A debit that succeeds with a nonzero remaining credit (after any same-cycle coin) enters CHANGE automatically at the next edge, as if refund_req had been asserted.
  - A debit that succeeds with zero remaining credit stays in IDLE with no change_done pulse.
- When undefined: credit is retained after a purchase until refund_req is asserted.

Test Plan:
- Reset, then insert quarter, quarter, dime -> credit = 60. coin_reject never asserts.
- credit = 60, debit_req with debit_amt = 75 -> debit_ack = 1, debit_ok = 0, credit stays 60.
- credit = 60, debit_amt = 45 -> debit_ok = 1, credit = 15. Then refund_req with change_ready held at 1:
  - change_coin sequence is dime then nickel, on two consecutive cycles;
  - change_done pulses once;
  - credit = 0.
- credit = 990, insert nickel -> credit = 995. Insert dime -> coin_reject pulses, credit stays 995.
- credit = 40, refund_req with change_ready low for 3 cycles -> quarter held stable on change_coin.
  - A coin inserted during this time -> coin_reject pulses.
  - Assert rst mid-sequence -> credit = 0, change_valid = 0 and state = IDLE after the next edge.
- With VM2002_AUTO_CHANGE_EN defined, credit = 100, debit_amt = 65 -> debit_ok = 1, then automatic change:
  - change_coin sequence is quarter, dime;
  - change_done pulses;
  - credit = 0.
